// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Latency: none (definitions only).
// Backpressure: not applicable.
package uart_arb_pkg;

    localparam int NREQ_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT_OK = 2'd2,
        ST_WAIT_LO = 2'd3
    } arb_state_e;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int idw_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin one-hot picker: first set req bit at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; grant is all zero when req is empty.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDW  = idw_of(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    always_comb begin
        int   cand;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = (int'(ptr) + i) % NREQ;
            if (!found && req[cand[IDW-1:0]]) begin
                found                 = 1'b1;
                grant[cand[IDW-1:0]]  = 1'b1;
                idx                   = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one uart_tx between NREQ byte requesters; UART_TX_ARB_PRIO_EN gives requester 0 strict priority.
// Latency: handshake edge to tx_start 1 cycle; tx_ok fall to done 1 cycle.
// Backpressure: req_ready only in IDLE with tx_en high; one frame in flight at a time.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDW  = idw_of(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   done,
    output logic              abort,
    input  logic              tx_en,
    input  logic              tx_ok,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic [IDW-1:0]    owner
);

    arb_state_e      state_q, state_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            abort_q, abort_d;
    logic            busy_q, busy_d;
    logic            tx_ok_q, tx_ok_d;

    logic [NREQ-1:0] pick_req, rr_grant, sel_grant;
    logic [IDW-1:0]  rr_idx, sel_idx;
    logic            sel_adv;

`ifdef UART_TX_ARB_PRIO_EN
    assign pick_req = {req_valid[NREQ-1:1], 1'b0};
`else
    assign pick_req = req_valid;
`endif

    uart_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req   (pick_req),
        .ptr   (ptr_q),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    always_comb begin
        sel_grant = rr_grant;
        sel_idx   = rr_idx;
        sel_adv   = 1'b1;
`ifdef UART_TX_ARB_PRIO_EN
        // Requester 0 jumps the queue without disturbing the rotation of the rest.
        if (req_valid[0]) begin
            sel_grant = NREQ'(1);
            sel_idx   = '0;
            sel_adv   = 1'b0;
        end
`endif
    end

    assign req_ready = (state_q == ST_IDLE && tx_en && !rst) ? sel_grant : '0;

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        done_d     = '0;
        abort_d    = 1'b0;
        tx_ok_d    = tx_ok;
        if (state_q != ST_IDLE && !tx_en) begin
            state_d = ST_IDLE;
            abort_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tx_en && |req_valid) begin
                        state_d    = ST_START;
                        tx_start_d = 1'b1;
                        tx_data_d  = req_data[{sel_idx, 3'b000} +: 8];
                        owner_d    = sel_idx;
                        if (sel_adv) begin
                            ptr_d = (int'(sel_idx) == NREQ - 1) ? '0 : sel_idx + IDW'(1);
                        end
                    end
                end
                ST_START:   state_d = ST_WAIT_OK;
                // Only a fresh rise counts; a level left over from the previous frame is stale.
                ST_WAIT_OK: if (tx_ok && !tx_ok_q) state_d = ST_WAIT_LO;
                ST_WAIT_LO: begin
                    if (!tx_ok) begin
                        state_d = ST_IDLE;
                        done_d  = NREQ'(1) << owner_q;
                    end
                end
                default:    state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            owner_q    <= '0;
            ptr_q      <= '0;
            done_q     <= '0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
            tx_ok_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            busy_q     <= busy_d;
            tx_ok_q    <= tx_ok_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign owner    = owner_q;
    assign done     = done_q;
    assign abort    = abort_q;
    assign busy     = busy_q;

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter and sequencer that shares one `uart_tx` transmitter between `NREQ` byte requesters. It accepts a byte from the winning requester and presents it on `tx_data`. It issues a one-cycle `tx_start` and tracks the transmitter's `tx_ok` pulse to detect frame completion. It sits between the requesters (CPU register port, DMA, debug) and `uart_tx`.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default 2: width of `owner`; must equal clog2(`NREQ`).

Ports:
- `clk`  in  1: system clock, same clock as `uart_tx`.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NREQ: per-requester byte pending; held until accepted.
- `req_data`  in  NREQ*8: byte of requester i on bits [8i+7:8i].
- `req_ready`  out  NREQ: one-hot accept; the handshake completes at an edge where `req_valid[i]` and `req_ready[i]` are both high.
- `done`  out  NREQ: one-hot, one-cycle pulse when requester i's frame completes.
- `abort`  out  1: one-cycle pulse when an in-flight frame is dropped.
- `tx_en`  in  1: same enable that drives `uart_tx`.
- `tx_ok`  in  1: frame-end indication from `uart_tx`.
- `tx_start`  out  1: start pulse to `uart_tx`.
- `tx_data`  out  8: byte to `uart_tx` `txd_in`.
- `busy`  out  1: high in every state except IDLE.
- `owner`  out  IDW: index of the requester currently being served.

## Operation
- FSM states: IDLE, START, WAIT_OK, WAIT_LO.
- IDLE, `tx_en`=1, any `req_valid`:
  - `req_ready` = grant vector, combinational, one-hot.
  - At that edge: latch `tx_data` and `owner`; set `ptr` = winner+1 mod NREQ; go to START.
  - If `tx_en`=0, `req_ready` is all zero.
- START: `tx_start`=1 for exactly this cycle; go to WAIT_OK.
- WAIT_OK: wait for `tx_ok`=1, then go to WAIT_LO.
- WAIT_LO: wait for `tx_ok`=0, then pulse `done[owner]` and return to IDLE.
  - The next grant can come in the cycle after `done`.
- Round robin: search order is `ptr`, `ptr`+1, … wrapping mod NREQ. The first valid requester wins.
- Abort: `tx_en`=0 in START, WAIT_OK or WAIT_LO:
  - Next state is IDLE; `abort` pulses; `tx_start` is forced 0; `done` does not pulse.
  - The accepted byte is lost and is not re-requested.
- `tx_en`=0 has priority over `tx_ok` in the same cycle.
- `tx_data` and `owner` stay stable from the grant edge until the FSM returns to IDLE.

## Timing
- Reset values: state IDLE, `tx_start` 0, `tx_data` 8'h00, `owner` 0, `ptr` 0, `done` 0, `abort` 0, `busy` 0. `req_ready` is 0 while `rst` is high.
- `tx_start`, `done`, `abort`, `busy`, `owner` and `tx_data` are registered. `req_ready` is combinational from state, `ptr`, `req_valid` and `tx_en`.
- Handshake edge to `tx_start` high: 1 cycle.
- `tx_ok` rise to state WAIT_LO: 1 cycle. `tx_ok` fall to `done` high: 1 cycle.
- `tx_ok` high while in IDLE or START is ignored. It is treated as stale from a prior frame.
- Reset mid-frame returns the FSM to IDLE immediately; no `done` or `abort` pulse is generated.

## Configuration
- Macro: `UART_TX_ARB_PRIO_EN`.
- Defined: requester 0 has strict priority. It wins whenever `req_valid[0]`=1 in IDLE and does not advance `ptr`. Requesters 1..NREQ-1 round-robin among themselves.
- Undefined: all `NREQ` requesters are pure round-robin as described above.

## Structure
- Package `uart_arb_pkg`:
  - FSM state encoding constants.
  - Default `NREQ`.
  - The IDW width constant/function.
- Sub-module `uart_rr_pick`: combinational round-robin one-hot picker with inputs `req`, `ptr` and outputs `grant`, `idx`. The top-level holds the FSM, registers and priority override.

## Test plan
- Single request: `req_valid`=4'b0010, `req_data[15:8]`=8'hA5, `tx_en`=1.
  - `req_ready`=4'b0010 for one cycle, then `tx_start` one cycle later with `tx_data`=8'hA5.
  - Model a `tx_ok` pulse; `done`=4'b0010 one cycle after `tx_ok` falls.
- Round robin: all four valid continuously from reset → grant order 0,1,2,3,0; each grant only after the previous `done`.
- Abort: drop `tx_en` during WAIT_OK → `abort` pulses once, no `done`, `busy`=0 next cycle, no `req_ready` while `tx_en`=0.
- Stale `tx_ok`: hold `tx_ok`=1 across the grant → no `done` until `tx_ok` falls, rises and falls again.
- `UART_TX_ARB_PRIO_EN` defined, all four valid → order 0,0,0…; with `req_valid[0]` deasserted after two grants → 1,2,3,1.
- Async `rst` asserted in WAIT_LO → all outputs at reset values within the same cycle. After release, the first grant goes to requester 0.
